// File: rtl/spi_stream_master.sv
// Byte-stream SPI master (mode 0) between host byte FIFOs and a boot flash.
// Command bytes from the input FWFT FIFO select END/WRITE/XFER/READ of N bytes;
// captured MISO bytes are pushed into the output FIFO.
//
// Ports:
//   bus_clk, rst        : sole clock, asynchronous active-high reset
//   enable              : stream open; low aborts any transfer next cycle
//   in_data/in_empty    : head of input FWFT FIFO; in_rden pops it (1-cycle pulse)
//   out_data/out_wren   : captured MISO byte and push strobe; out_full stalls
//   spi_cs_n/sclk/mosi  : flash chip select, clock (idle low), data out MSB first
//   spi_miso            : flash data in, sampled on SCLK rising edge
//   busy                : state != IDLE or chip select asserted
module spi_stream_master #(
    parameter int CLKDIV = 2
) (
    input  logic       bus_clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] in_data,
    input  logic       in_empty,
    output logic       in_rden,
    output logic [7:0] out_data,
    output logic       out_wren,
    input  logic       out_full,
    output logic       spi_cs_n,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       busy
);

    localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [DW-1:0] DMAX = DW'(CLKDIV - 1);

    localparam logic [1:0] OP_END   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_CSSETUP,
        S_LOAD,
        S_SHIFT,
        S_STORE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [5:0]      count_q, count_d;
    logic [DW-1:0]   div_q, div_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      tx_q, tx_d;
    logic [7:0]      rx_q, rx_d;
    logic            cs_n_q, cs_n_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic            rden_q, rden_d;
    logic            wren_q, wren_d;
    logic [7:0]      odata_q, odata_d;
    logic            busy_q, busy_d;

    always_ff @(posedge bus_clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_END;
            count_q <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            rden_q  <= 1'b0;
            wren_q  <= 1'b0;
            odata_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            count_q <= count_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            rden_q  <= rden_d;
            wren_q  <= wren_d;
            odata_q <= odata_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        count_d = count_q;
        div_d   = div_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        rden_d  = 1'b0;
        wren_d  = 1'b0;
        odata_d = odata_q;

        case (state_q)
            S_IDLE: begin
                if (enable && !in_empty) begin
                    rden_d  = 1'b1;
                    op_d    = in_data[7:6];
                    count_d = in_data[5:0];
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (op_q == OP_END) begin
                    cs_n_d  = 1'b1;
                    count_d = '0;
                    state_d = S_IDLE;
                end else if (cs_n_q) begin
                    // Fresh select: hold CS low CLKDIV cycles before SCLK.
                    cs_n_d  = 1'b0;
                    div_d   = '0;
                    state_d = S_CSSETUP;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_CSSETUP: begin
                if (div_q == DMAX) begin
                    div_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_LOAD: begin
                if (op_q == OP_READ) begin
                    tx_d    = 8'h00;
                    mosi_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                    state_d = S_SHIFT;
                end else if (!in_empty) begin
                    rden_d  = 1'b1;
                    tx_d    = in_data;
                    mosi_d  = in_data[7];
                    div_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (div_q == DMAX) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        // Rising edge: sample MISO.
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[6:0], spi_miso};
                    end else begin
                        // Falling edge: advance MOSI or finish the byte.
                        sclk_d = 1'b0;
                        if (bit_q == 3'd7) begin
                            state_d = S_STORE;
                        end else begin
                            bit_d  = bit_q + 3'd1;
                            tx_d   = tx_q << 1;
                            mosi_d = tx_q[6];
                        end
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_STORE: begin
                if (op_q == OP_WRITE || !out_full) begin
                    if (op_q != OP_WRITE) begin
                        wren_d  = 1'b1;
                        odata_d = rx_q;
                    end
                    if (count_q == 6'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        count_d = count_q - 6'd1;
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort: drop the partial byte and release the flash.
        if (!enable) begin
            state_d = S_IDLE;
            count_d = '0;
            div_d   = '0;
            bit_d   = '0;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
            rden_d  = 1'b0;
            wren_d  = 1'b0;
        end

        busy_d = (state_d != S_IDLE) || !cs_n_d;
    end

    assign in_rden  = rden_q;
    assign out_wren = wren_q;
    assign out_data = odata_q;
    assign spi_cs_n = cs_n_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;
    assign busy     = busy_q;

endmodule
